// File: rtl/baccarat_deal_fsm.sv
// rtl/baccarat_deal_fsm.sv - dealing sequencer and win-light latch for one baccarat hand
//
// Purpose:
//   Steps through the deal (P1 D1 P2 D2), evaluates naturals and the
//   third-card rules against the scorer outputs, and latches the win lights.
//
// Ports:
//   slow_clock    in   1  clock, all state updates on posedge
//   reset         in   1  synchronous active-high reset
//   step          in   1  advance request, one-cycle pulse
//   pscore        in   4  player hand score 0-9
//   dscore        in   4  dealer hand score 0-9
//   pcard3        in   4  player third-card rank 0-13 (0 = none)
//   load_pcard1..3, load_dcard1..3
//                 out  1  one-cycle card-register load enables, at most one high
//   player_win    out  1  registered player win light
//   dealer_win    out  1  registered dealer win light
//   done          out  1  hand complete
//   natural       out  1  hand ended on a natural (only with NATURAL_FLAG_EN)
//
// Parameters:
//   TIE_BOTH      1 -> both lights on a tie, 0 -> both off
//
// Configuration macro:
//   NATURAL_FLAG_EN  adds the natural output

module baccarat_deal_fsm #(
  parameter bit TIE_BOTH = 1'b1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win,
  output logic       dealer_win,
`ifdef NATURAL_FLAG_EN
  output logic       natural,
`endif
  output logic       done
);

  typedef enum logic [3:0] {
    S_P1    = 4'd0,
    S_P2    = 4'd1,
    S_D1    = 4'd2,
    S_D2    = 4'd3,
    S_EVAL4 = 4'd4,
    S_P3    = 4'd5,
    S_EVALD = 4'd6,
    S_D3    = 4'd7,
    S_FINAL = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_player_win;
  logic       r_dealer_win;
  logic       w_step_ok;
  logic       w_natural;
  logic [3:0] w_v;
  logic       w_dealer_draw;

`ifdef NATURAL_FLAG_EN
  logic       r_nat_path;
  logic       r_natural;
  assign natural = r_natural;
`endif

  assign player_win = r_player_win;
  assign dealer_win = r_dealer_win;

  // Reset has priority over step, so a load pulse never escapes a reset cycle.
  assign w_step_ok = step & ~reset;
  assign w_natural = (pscore >= 4'd8) || (dscore >= 4'd8);

  // Third-card value: face ranks 10-13 count as zero.
  assign w_v = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

  always_comb begin
    w_dealer_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_dealer_draw = 1'b1;
      4'd3:             w_dealer_draw = (w_v != 4'd8);
      4'd4:             w_dealer_draw = (w_v >= 4'd2) && (w_v <= 4'd7);
      4'd5:             w_dealer_draw = (w_v >= 4'd4) && (w_v <= 4'd7);
      4'd6:             w_dealer_draw = (w_v >= 4'd6) && (w_v <= 4'd7);
      default:          w_dealer_draw = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_P1: begin
        load_pcard1 = w_step_ok;
        if (step) w_next = S_D1;
      end
      S_D1: begin
        load_dcard1 = w_step_ok;
        if (step) w_next = S_P2;
      end
      S_P2: begin
        load_pcard2 = w_step_ok;
        if (step) w_next = S_D2;
      end
      S_D2: begin
        load_dcard2 = w_step_ok;
        if (step) w_next = S_EVAL4;
      end
      S_EVAL4: begin
        if (w_natural)              w_next = S_FINAL;
        else if (pscore <= 4'd5)    w_next = S_P3;
        else if (dscore <= 4'd5)    w_next = S_D3;
        else                        w_next = S_FINAL;
      end
      S_P3: begin
        load_pcard3 = w_step_ok;
        if (step) w_next = S_EVALD;
      end
      S_EVALD: begin
        w_next = w_dealer_draw ? S_D3 : S_FINAL;
      end
      S_D3: begin
        load_dcard3 = w_step_ok;
        if (step) w_next = S_FINAL;
      end
      S_FINAL: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        w_next = S_P1;
      end
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_state      <= S_P1;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
`ifdef NATURAL_FLAG_EN
      r_nat_path   <= 1'b0;
      r_natural    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_FINAL) begin
        if (pscore == dscore) begin
          r_player_win <= TIE_BOTH;
          r_dealer_win <= TIE_BOTH;
        end else begin
          r_player_win <= (pscore > dscore);
          r_dealer_win <= (dscore > pscore);
        end
      end
`ifdef NATURAL_FLAG_EN
      // Remember whether EVAL4 short-circuited on a natural; published in FINAL.
      if (r_state == S_EVAL4) r_nat_path <= w_natural;
      if (r_state == S_FINAL) r_natural  <= r_nat_path;
`endif
    end
  end

endmodule
